bictr_dcnto_multi: RTL

- Multi-channel up/down binary counter bank with a per-channel dynamic count-to compare and a per-channel run mode: free-run, auto-reload or one-shot.
- Successor to the single-channel dynamic-count-to counter. Used as the shared timer/event-counter bank in the datapath control area.
- All channels share one clock and one reset, and are otherwise independent.

---
 rtl/bictr_pkg.sv | 10 +
 rtl/bictr_dcnto_chan.sv | 73 +++++++
 rtl/bictr_dcnto_multi.sv | 51 +++++
 3 files changed

// File: rtl/bictr_pkg.sv
// Shared mode encoding for the multi-channel dynamic count-to counter bank.
package bictr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FREE    = 2'b00;
  localparam mode_t MODE_RELOAD  = 2'b01;
  localparam mode_t MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/bictr_dcnto_chan.sv
// One counter channel: up/down count, dynamic terminal compare, run mode, done flag.
// Optional sticky terminal-hit status when BICTR_DCNTO_IRQ_EN is defined.
module bictr_dcnto_chan
  import bictr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             up_dn,
  input  logic             load,
  input  logic             cen,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] count_to,
`ifdef BICTR_DCNTO_IRQ_EN
  input  logic             irq_clr,
  output logic             irq_stat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tercnt,
  output logic             done
);

  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count_nxt;
  logic             done_nxt;

  assign tercnt = (count == count_to);
  assign step   = up_dn ? count + WIDTH'(1) : count - WIDTH'(1);

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    done_nxt  = done;
    if (!load) begin
      count_nxt = data;
      done_nxt  = 1'b0;
    end else if (cen) begin
      case (mode)
        MODE_RELOAD:  count_nxt = tercnt ? data : step;
        MODE_ONESHOT: begin
          if (!done) begin
            if (tercnt) done_nxt  = 1'b1;
            else        count_nxt = step;
          end
        end
        default:      count_nxt = step;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all channels update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

`ifdef BICTR_DCNTO_IRQ_EN
  // A terminal hit on a counting edge takes precedence over a same-edge clear.
  always_ff @(posedge clk) begin
    if (!reset)                     irq_stat <= 1'b0;
    else if (cen && load && tercnt) irq_stat <= 1'b1;
    else if (irq_clr)               irq_stat <= 1'b0;
  end
`endif

endmodule

// File: rtl/bictr_dcnto_multi.sv
// Bank of CHANNELS independent dynamic count-to counters sharing clk and reset.
// Define BICTR_DCNTO_IRQ_EN to add per-channel sticky status and a combined irq.
module bictr_dcnto_multi
  import bictr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [CHANNELS-1:0]       up_dn,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       cen,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS*WIDTH-1:0] count_to,
`ifdef BICTR_DCNTO_IRQ_EN
  input  logic [CHANNELS-1:0]       irq_clr,
  output logic [CHANNELS-1:0]       irq_stat,
  output logic                      irq,
`endif
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tercnt,
  output logic [CHANNELS-1:0]       done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    bictr_dcnto_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .data     (data[i*WIDTH +: WIDTH]),
      .up_dn    (up_dn[i]),
      .load     (load[i]),
      .cen      (cen[i]),
      .mode     (mode_t'(mode[2*i +: 2])),
      .count_to (count_to[i*WIDTH +: WIDTH]),
`ifdef BICTR_DCNTO_IRQ_EN
      .irq_clr  (irq_clr[i]),
      .irq_stat (irq_stat[i]),
`endif
      .count    (count[i*WIDTH +: WIDTH]),
      .tercnt   (tercnt[i]),
      .done     (done[i])
    );
  end

`ifdef BICTR_DCNTO_IRQ_EN
  assign irq = |irq_stat;
`endif

endmodule
